// File: rtl/fp_pkg.sv
// Shared types and helpers for the IEEE-754 add/subtract unit.
package fp_pkg;

   localparam int unsigned W          = 32;
   localparam int unsigned BIAS       = 127;
   localparam int unsigned QNAN_MAX_W = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } fp_state_e;

   typedef enum logic [2:0] {
      C_ZERO,
      C_SUB,
      C_NORM,
      C_INF,
      C_QNAN,
      C_SNAN
   } fp_class_e;

   // Width-independent classification from the exponent/fraction summary bits
   function automatic fp_class_e fp_classify(input logic exp_zero,
                                             input logic exp_ones,
                                             input logic frac_zero,
                                             input logic frac_msb);
      fp_class_e c;
      c = C_NORM;
      if (exp_zero) begin
         c = frac_zero ? C_ZERO : C_SUB;
      end else if (exp_ones) begin
         if (frac_zero) c = C_INF;
         else           c = frac_msb ? C_QNAN : C_SNAN;
      end
      return c;
   endfunction

   // Canonical quiet NaN {0, 1..1, 1, 0..0}, right-aligned in a wide word
   function automatic logic [QNAN_MAX_W-1:0] qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
      logic [QNAN_MAX_W-1:0] q;
      q = (((QNAN_MAX_W'(1) << exp_w) - QNAN_MAX_W'(1)) << man_w)
          | (QNAN_MAX_W'(1) << (man_w - 1));
      return q;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter  int unsigned WIDTH = 27,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CNT_W-1:0] lz_c
);

   // Scan upward so the highest set bit determines the count
   always_comb begin
      lz_c = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) lz_c = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// IEEE-754 add/subtract, RNE, fixed 4-cycle latency, one operation in flight.
// Build option FP_DENORM_EN: gradual underflow; otherwise subnormals flush to zero.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 zero,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact,
   output logic                 invalid
);

   localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
   localparam int unsigned SIG_W  = MAN_W + 4;   // hidden, fraction, G, R, S
   localparam int unsigned IEXP_W = EXP_W + 2;   // headroom for carry and rounding
   localparam int unsigned MNT_W  = MAN_W + 2;
   localparam int unsigned LZ_W   = $clog2(SIG_W + 1);
   localparam int unsigned SH_MAX = MAN_W + 3;

   localparam logic [IEXP_W-1:0] EXP_ONE  = IEXP_W'(1);
   localparam logic [IEXP_W-1:0] EXP_ONES = IEXP_W'({EXP_W{1'b1}});
   localparam logic [IEXP_W-1:0] SH_SAT   = IEXP_W'(SH_MAX);
   localparam logic [WORD_W-1:0] QNAN_W   = WORD_W'(qnan(EXP_W, MAN_W));

   // ---------------------------------------------------------------- control
   fp_state_e state, state_nx;
   logic      in_ready_nx, out_valid_nx;

   always_comb begin
      state_nx     = state;
      in_ready_nx  = 1'b0;
      out_valid_nx = 1'b0;
      case (state)
         S_IDLE:  if (in_valid) state_nx = S_ALIGN;
         S_ALIGN: state_nx = S_ADD;
         S_ADD:   state_nx = S_NORM;
         S_NORM:  state_nx = S_ROUND;
         S_ROUND: state_nx = S_DONE;
         S_DONE:  if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      in_ready_nx  = (state_nx == S_IDLE);
      out_valid_nx = (state_nx == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         in_ready  <= in_ready_nx;
         out_valid <= out_valid_nx;
      end
   end

   // ---------------------------------------------------------------- datapath
   logic [WORD_W-1:0] a_r, b_r;
   logic              op_r;

   logic              sa, sb;
   logic [EXP_W-1:0]  ea, eb;
   logic [MAN_W-1:0]  fa, fb;
   fp_class_e         ca, cb;
   logic [SIG_W-1:0]  siga, sigb, sig_big, sig_small, sig_small_sh;
   logic [IEXP_W-1:0] ea_eff, eb_eff, exp_big, exp_small, exp_diff, shamt;
   logic              a_big, lost;
   logic              spec, spec_inv;
   logic [WORD_W-1:0] spec_res;

   // Unpack, classify, resolve specials and align the smaller operand
   always_comb begin
      sa = a_r[WORD_W-1];
      sb = b_r[WORD_W-1] ^ op_r;
      ea = a_r[WORD_W-2 -: EXP_W];
      eb = b_r[WORD_W-2 -: EXP_W];
      fa = a_r[MAN_W-1:0];
      fb = b_r[MAN_W-1:0];
      ca = fp_classify(ea == '0, ea == '1, fa == '0, fa[MAN_W-1]);
      cb = fp_classify(eb == '0, eb == '1, fb == '0, fb[MAN_W-1]);
`ifdef FP_DENORM_EN
      siga = {ca == C_NORM, fa, 3'b000};
      sigb = {cb == C_NORM, fb, 3'b000};
`else
      siga = (ca == C_SUB) ? '0 : {ca == C_NORM, fa, 3'b000};
      sigb = (cb == C_SUB) ? '0 : {cb == C_NORM, fb, 3'b000};
`endif
      ea_eff = (ea == '0) ? EXP_ONE : IEXP_W'(ea);
      eb_eff = (eb == '0) ? EXP_ONE : IEXP_W'(eb);

      a_big     = {ea_eff, siga} >= {eb_eff, sigb};
      sig_big   = a_big ? siga   : sigb;
      sig_small = a_big ? sigb   : siga;
      exp_big   = a_big ? ea_eff : eb_eff;
      exp_small = a_big ? eb_eff : ea_eff;
      exp_diff  = exp_big - exp_small;
      shamt     = (exp_diff > SH_SAT) ? SH_SAT : exp_diff;

      lost         = |(sig_small & ~({SIG_W{1'b1}} << shamt));
      sig_small_sh = sig_small >> shamt;
      sig_small_sh[0] = sig_small_sh[0] | lost;

      spec     = 1'b0;
      spec_inv = 1'b0;
      spec_res = '0;
      if (ca == C_QNAN || ca == C_SNAN || cb == C_QNAN || cb == C_SNAN) begin
         spec     = 1'b1;
         spec_res = QNAN_W;
         spec_inv = (ca == C_SNAN) || (cb == C_SNAN);
      end else if (ca == C_INF && cb == C_INF && sa != sb) begin
         spec     = 1'b1;
         spec_res = QNAN_W;
         spec_inv = 1'b1;
      end else if (ca == C_INF) begin
         spec     = 1'b1;
         spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (cb == C_INF) begin
         spec     = 1'b1;
         spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   logic [SIG_W-1:0]  sig_x_r, sig_y_r;
   logic [IEXP_W-1:0] exp_r;
   logic              sign_r, sub_r;
   logic              spec_r, spec_inv_r;
   logic [WORD_W-1:0] spec_res_r;
   logic [SIG_W:0]    sum_r;

   // Normalisation: carry-out shifts right, otherwise left by the clamped lz count
   logic [LZ_W-1:0]   lz;
   logic [IEXP_W-1:0] lz_ext, exp_m1, lsh, nexp;
   logic [SIG_W-1:0]  nsig;

   fp_lzc #(.WIDTH(SIG_W)) u_lzc (
      .value (sum_r[SIG_W-1:0]),
      .lz_c  (lz)
   );

   always_comb begin
      lz_ext = IEXP_W'(lz);
      exp_m1 = exp_r - EXP_ONE;
      lsh    = '0;
      nsig   = '0;
      nexp   = exp_r;
      if (sum_r[SIG_W]) begin
         nsig = {sum_r[SIG_W:2], sum_r[1] | sum_r[0]};
         nexp = exp_r + EXP_ONE;
      end else begin
         lsh  = (lz_ext > exp_m1) ? exp_m1 : lz_ext;
         nsig = sum_r[SIG_W-1:0] << lsh;
         nexp = exp_r - lsh;
      end
   end

   logic [SIG_W-1:0]  nsig_r;
   logic [IEXP_W-1:0] nexp_r;
   logic              nzero_r;

   always_ff @(posedge clk) begin
      if (state == S_IDLE && in_valid) begin
         a_r  <= a;
         b_r  <= b;
         op_r <= op;
      end
      if (state == S_ALIGN) begin
         sig_x_r    <= sig_big;
         sig_y_r    <= sig_small_sh;
         exp_r      <= exp_big;
         sign_r     <= a_big ? sa : sb;
         sub_r      <= sa ^ sb;
         spec_r     <= spec;
         spec_inv_r <= spec_inv;
         spec_res_r <= spec_res;
      end
      if (state == S_ADD) begin
         sum_r <= sub_r ? ({1'b0, sig_x_r} - {1'b0, sig_y_r})
                        : ({1'b0, sig_x_r} + {1'b0, sig_y_r});
      end
      if (state == S_NORM) begin
         nsig_r  <= nsig;
         nexp_r  <= nexp;
         nzero_r <= (sum_r == '0);
      end
   end

   // Round to nearest even and assemble the final word and flags
   logic              g, r, s, rnd_up, tiny, inex;
   logic [MNT_W-1:0]  mant;
   logic [MAN_W:0]    mant_fin;
   logic [IEXP_W-1:0] rexp;
   logic [EXP_W-1:0]  exp_field;
   logic [WORD_W-1:0] res_nx;
   logic              ovf_nx, unf_nx, inex_nx, inv_nx;

   always_comb begin
      g        = nsig_r[2];
      r        = nsig_r[1];
      s        = nsig_r[0];
      inex     = g | r | s;
      rnd_up   = g & (r | s | nsig_r[3]);
      mant     = {1'b0, nsig_r[SIG_W-1:3]} + MNT_W'(rnd_up);
      mant_fin = mant[MAN_W+1] ? mant[MAN_W+1:1] : mant[MAN_W:0];
      rexp     = mant[MAN_W+1] ? (nexp_r + EXP_ONE) : nexp_r;
      exp_field = mant_fin[MAN_W] ? rexp[EXP_W-1:0] : '0;
      tiny     = !nsig_r[SIG_W-1] && !nzero_r;

      res_nx  = '0;
      ovf_nx  = 1'b0;
      unf_nx  = 1'b0;
      inex_nx = 1'b0;
      inv_nx  = 1'b0;
      if (spec_r) begin
         res_nx = spec_res_r;
         inv_nx = spec_inv_r;
      end else if (nzero_r) begin
         res_nx = {sub_r ? 1'b0 : sign_r, {(WORD_W-1){1'b0}}};
      end else if (rexp >= EXP_ONES) begin
         res_nx  = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         ovf_nx  = 1'b1;
         inex_nx = 1'b1;
      end else if (tiny) begin
`ifdef FP_DENORM_EN
         res_nx  = {sign_r, exp_field, mant_fin[MAN_W-1:0]};
         inex_nx = inex;
         unf_nx  = inex;
`else
         res_nx  = {sign_r, {(WORD_W-1){1'b0}}};
         inex_nx = 1'b1;
         unf_nx  = 1'b1;
`endif
      end else begin
         res_nx  = {sign_r, exp_field, mant_fin[MAN_W-1:0]};
         inex_nx = inex;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
         invalid   <= 1'b0;
      end else if (state == S_ROUND) begin
         result    <= res_nx;
         zero      <= (res_nx[WORD_W-2:0] == '0);
         overflow  <= ovf_nx;
         underflow <= unf_nx;
         inexact   <= inex_nx;
         invalid   <= inv_nx;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed vector table, handshake/reset sequences,
// and random operands against an exact-arithmetic reference model.
module tb_fp_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, op, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic        zero, overflow, underflow, inexact, invalid;

   int checks = 0;
   int passed = 0;

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .overflow(overflow), .underflow(underflow),
      .inexact(inexact), .invalid(invalid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] res;
      logic [4:0]  fl;   // {zero, overflow, underflow, inexact, invalid}
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  fl;
   } exp_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %08h want %08h", name, got, want);
   endtask

   function automatic logic [4:0] flags_now();
      return {zero, overflow, underflow, inexact, invalid};
   endfunction

   // Exact sum in units of 2^-149, then a single RNE rounding to binary32
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic sub);
      exp_t        rr;
      logic        sx, sy, sr, xnan, ynan, xsnan, ysnan, xinf, yinf, half, rest;
      logic [7:0]  ex, ey;
      logic [22:0] fx, fy;
      logic [299:0] vx, vy, m;
      logic [24:0] q;
      int          p, e, sh;
      rr = '0;
      sx = x[31]; sy = y[31] ^ sub;
      ex = x[30:23]; ey = y[30:23];
      fx = x[22:0];  fy = y[22:0];
      xnan = (ex == 8'hFF) && (fx != 0); xsnan = xnan && !fx[22];
      ynan = (ey == 8'hFF) && (fy != 0); ysnan = ynan && !fy[22];
      xinf = (ex == 8'hFF) && (fx == 0);
      yinf = (ey == 8'hFF) && (fy == 0);
      if (xnan || ynan) begin
         rr.res = 32'h7FC00000; rr.fl = {4'b0000, xsnan || ysnan}; return rr;
      end
      if (xinf && yinf && sx != sy) begin
         rr.res = 32'h7FC00000; rr.fl = 5'b00001; return rr;
      end
      if (xinf) begin rr.res = {sx, 8'hFF, 23'd0}; return rr; end
      if (yinf) begin rr.res = {sy, 8'hFF, 23'd0}; return rr; end
`ifdef FP_DENORM_EN
      vx = (ex == 0) ? 300'(fx) : (300'({1'b1, fx}) << (ex - 1));
      vy = (ey == 0) ? 300'(fy) : (300'({1'b1, fy}) << (ey - 1));
`else
      vx = (ex == 0) ? '0 : (300'({1'b1, fx}) << (ex - 1));
      vy = (ey == 0) ? '0 : (300'({1'b1, fy}) << (ey - 1));
`endif
      if (sx == sy)     begin m = vx + vy; sr = sx; end
      else if (vx > vy) begin m = vx - vy; sr = sx; end
      else if (vy > vx) begin m = vy - vx; sr = sy; end
      else              begin m = '0;      sr = 1'b0; end
      if (m == '0) begin rr.res = {sr, 31'd0}; rr.fl = 5'b10000; return rr; end
      p = -1;
      for (int i = 0; i < 300; i++) if (m[i]) p = i;
      if (p < 23) begin
`ifdef FP_DENORM_EN
         rr.res = {sr, 8'd0, m[22:0]}; rr.fl = 5'b00000;
`else
         rr.res = {sr, 31'd0}; rr.fl = 5'b10110;
`endif
         return rr;
      end
      e = p - 22; sh = p - 23;
      q = 25'(m >> sh);
      half = 1'b0; rest = 1'b0;
      if (sh > 0) begin
         half = m[sh-1];
         rest = ((m & ((300'(1) << (sh - 1)) - 300'(1))) != '0);
      end
      if (half && (rest || q[0])) q = q + 25'd1;
      if (q[24]) begin q = q >> 1; e = e + 1; end
      if (e >= 255) begin rr.res = {sr, 8'hFF, 23'd0}; rr.fl = 5'b01010; return rr; end
      rr.res = {sr, 8'(e), q[22:0]};
      rr.fl  = {3'b000, half | rest, 1'b0};
      return rr;
   endfunction

   // Issue one operation, wait for the result, then complete the handshake
   task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                        output logic [31:0] res, output logic [4:0] fl, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      a = xa; b = xb; op = xop; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
      res = result;
      fl  = flags_now();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic [31:0] rand_fp();
      int          k;
      logic [31:0] f;
      k = $urandom_range(0, 19);
      f = $urandom;
      case (k)
         0:       return {f[31], 31'd0};
         1:       return {f[31], 8'h00, f[22:0]};
         2:       return {f[31], 8'hFF, 23'd0};
         3:       return {f[31], 8'hFF, f[22], f[21:0] | 22'd1};
         4, 5:    return {f[31], 8'($urandom_range(250, 254)), f[22:0]};
         6, 7:    return {f[31], 8'($urandom_range(1, 3)), f[22:0]};
         default: return {f[31], 8'($urandom_range(100, 154)), f[22:0]};
      endcase
   endfunction

   localparam int NV = 17;
   vec_t        vecs[NV];
   logic [31:0] got_res, ra, rb, hold_res;
   logic [4:0]  got_fl;
   int          lat;
   exp_t        want;

   initial begin
      vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 5'b00000};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 5'b10000};
      vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 5'b10000};
      vecs[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 5'b00001};
      vecs[4]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00001};
      vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5'b01010};
      vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5'b00010};
      vecs[7]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 5'b00010};
`ifdef FP_DENORM_EN
      vecs[8]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 5'b00000};
`else
      vecs[8]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 5'b10110};
`endif
      vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000};
      vecs[10] = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 5'b00000};
      vecs[11] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 5'b00000};
      vecs[12] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5'b00000};
      vecs[13] = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 5'b00000};
      vecs[14] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 5'b10000};
      vecs[15] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 5'b00001};
      vecs[16] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_in_ready",  32'(in_ready),   32'd1);
      check("reset_out_valid", 32'(out_valid),  32'd0);
      check("reset_result",    result,          32'd0);
      check("reset_flags",     32'(flags_now()), 32'd0);

      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].op, got_res, got_fl, lat);
         check($sformatf("vec%0d_result", i), got_res, vecs[i].res);
         check($sformatf("vec%0d_flags", i), 32'(got_fl), 32'(vecs[i].fl));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      end

      // Result held while the consumer stalls; new inputs are ignored
      a = 32'h3F800000; b = 32'h40000000; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      hold_res = 32'h40400000;
      a = 32'h41200000; b = 32'h41200000; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("stall_result", result, hold_res);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check("handshake_in_ready", 32'(in_ready), 32'd1);
      check("handshake_out_valid", 32'(out_valid), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      check("no_spurious_op", 32'(out_valid), 32'd0);

      // Reset while an operation is in flight drops it
      a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_in_ready", 32'(in_ready), 32'd1);
      check("midreset_result", result, 32'd0);
      repeat (6) @(posedge clk);
      #1;
      check("midreset_dropped", 32'(out_valid), 32'd0);

      // Reset while holding a result in DONE
      a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("donereset_out_valid", 32'(out_valid), 32'd0);
      check("donereset_flags", 32'(flags_now()), 32'd0);

      for (int i = 0; i < 300; i++) begin
         ra = rand_fp();
         if ($urandom_range(0, 1) == 1 && ra[30:23] != 8'h00 && ra[30:23] != 8'hFF) begin
            rb = {1'($urandom_range(0, 1)),
                  8'(int'(ra[30:23]) + ((ra[30:23] > 8'd1 && ra[30:23] < 8'd254) ?
                                        $urandom_range(0, 2) - 1 : 0)),
                  ra[22:0] ^ 23'($urandom_range(0, 15))};
         end else begin
            rb = rand_fp();
         end
         op = 1'($urandom_range(0, 1));
         want = model(ra, rb, op);
         do_op(ra, rb, op, got_res, got_fl, lat);
         if (got_res !== want.res || got_fl !== want.fl)
            $display("  operands a=%08h b=%08h op=%0d", ra, rb, op);
         check("rand_result", got_res, want.res);
         check("rand_flags", 32'(got_fl), 32'(want.fl));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
